cla_8_bit: RTL and testbench



---
 rtl/cla_8_bit_pkg.sv | 11 +
 rtl/cla_4bit_group.sv | 36 +++
 rtl/cla_8_bit.sv | 60 ++++++
 tb/tb_cla_8_bit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cla_8_bit_pkg.sv
// Shared widths and reset values for the registered 8-bit carry-lookahead adder.
package cla_8_bit_pkg;

  localparam int unsigned ADD_W   = 8;
  localparam int unsigned GRP_W   = 4;
  localparam int unsigned NUM_GRP = ADD_W / GRP_W;

  localparam logic [ADD_W-1:0] RST_S    = '0;
  localparam logic             RST_COUT = 1'b0;

endpackage

// File: rtl/cla_4bit_group.sv
// 4-bit carry-lookahead group: full-expansion internal carries, sum bits,
// and group generate/propagate for the next lookahead level.
module cla_4bit_group
  import cla_8_bit_pkg::*;
(
  input  logic [GRP_W-1:0] a,
  input  logic [GRP_W-1:0] b,
  input  logic             cin,
  output logic [GRP_W-1:0] s,
  output logic             gg,
  output logic             gp
);

  logic [GRP_W-1:0] w_g;
  logic [GRP_W-1:0] w_p;
  logic [GRP_W-1:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Every carry is a flat sum-of-products of cin, so no carry waits on its neighbour.
  always_comb begin
    w_c    = '0;
    w_c[0] = cin;
    w_c[1] = w_g[0] | (w_p[0] & cin);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & cin);
  end

  assign s  = w_p ^ w_c;
  assign gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
            | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign gp = &w_p;

endmodule

// File: rtl/cla_8_bit.sv
// Registered 8-bit adder: two lookahead groups joined by a group carry unit,
// result captured in a single output register stage.
module cla_8_bit
  import cla_8_bit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  output logic [ADD_W-1:0] S,
  output logic             Cout,
  input  logic [ADD_W-1:0] A,
  input  logic [ADD_W-1:0] B,
  input  logic             Cin
);

  logic [ADD_W-1:0]   w_s_next;
  logic [NUM_GRP-1:0] w_gg;
  logic [NUM_GRP-1:0] w_gp;
  logic               w_c4;
  logic               w_c8;
  logic [ADD_W-1:0]   r_s;
  logic               r_cout;

  cla_4bit_group u_grp0 (
    .a   (A[GRP_W-1:0]),
    .b   (B[GRP_W-1:0]),
    .cin (Cin),
    .s   (w_s_next[GRP_W-1:0]),
    .gg  (w_gg[0]),
    .gp  (w_gp[0])
  );

  cla_4bit_group u_grp1 (
    .a   (A[ADD_W-1:GRP_W]),
    .b   (B[ADD_W-1:GRP_W]),
    .cin (w_c4),
    .s   (w_s_next[ADD_W-1:GRP_W]),
    .gg  (w_gg[1]),
    .gp  (w_gp[1])
  );

  // c8 is expanded from Cin directly rather than from c4 to keep the groups parallel.
  always_comb begin
    w_c4 = w_gg[0] | (w_gp[0] & Cin);
    w_c8 = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & Cin);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s    <= RST_S;
      r_cout <= RST_COUT;
    end else begin
      r_s    <= w_s_next;
      r_cout <= w_c8;
    end
  end

  assign S    = r_s;
  assign Cout = r_cout;

endmodule

// File: tb/tb_cla_8_bit.sv
// Directed and random checks of the registered 8-bit carry-lookahead adder.
module tb_cla_8_bit;

  logic       clk;
  logic       rst;
  logic [7:0] S;
  logic       Cout;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;

  int checks;
  int errors;

  // Packed vector layout: {A, B, Cin, S_expected, Cout_expected}
  localparam logic [25:0] DIR_VEC [4] = '{
    {8'h00, 8'h00, 1'b0, 8'h00, 1'b0},
    {8'h11, 8'h00, 1'b0, 8'h11, 1'b0},
    {8'h34, 8'h63, 1'b0, 8'h97, 1'b0},
    {8'h1E, 8'h69, 1'b0, 8'h87, 1'b0}
  };
  localparam logic [25:0] CARRY_VEC [2] = '{
    {8'hD9, 8'hA6, 1'b1, 8'h80, 1'b1},
    {8'hFF, 8'hAA, 1'b0, 8'hA9, 1'b1}
  };
  localparam logic [25:0] PROP_VEC [3] = '{
    {8'hFF, 8'h00, 1'b1, 8'h00, 1'b1},
    {8'h0F, 8'h00, 1'b1, 8'h10, 1'b0},
    {8'hF0, 8'h10, 1'b0, 8'h00, 1'b1}
  };

  cla_8_bit dut (
    .clk  (clk),
    .rst  (rst),
    .S    (S),
    .Cout (Cout),
    .A    (A),
    .B    (B),
    .Cin  (Cin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got checks=%0d required completion", checks);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1;
    A   = 8'hFF;
    B   = 8'hFF;
    Cin = 1'b1;
    #1;
    checks++;
    if ({Cout, S} !== 9'h000) begin
      errors++;
      $display("FAIL reset_initial: got Cout=%b S=%h required Cout=0 S=00", Cout, S);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({Cout, S} !== 9'h000) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got Cout=%b S=%h required Cout=0 S=00", i, Cout, S);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({Cout, S} !== 9'h1FF) begin
      errors++;
      $display("FAIL reset_release_load: got Cout=%b S=%h required Cout=1 S=ff", Cout, S);
    end
  endtask

  task automatic test_directed();
    logic [25:0] v;
    for (int i = 0; i < 4; i++) begin
      v = DIR_VEC[i];
      @(negedge clk);
      A = v[25:18]; B = v[17:10]; Cin = v[9];
      @(posedge clk);
      #1;
      checks++;
      if (S !== v[8:1] || Cout !== v[0]) begin
        errors++;
        $display("FAIL directed[%0d] %h+%h+%b: got Cout=%b S=%h required Cout=%b S=%h",
                 i, v[25:18], v[17:10], v[9], Cout, S, v[0], v[8:1]);
      end
    end
  endtask

  task automatic test_carry_out();
    logic [25:0] v;
    for (int i = 0; i < 2; i++) begin
      v = CARRY_VEC[i];
      @(negedge clk);
      A = v[25:18]; B = v[17:10]; Cin = v[9];
      @(posedge clk);
      #1;
      checks++;
      if (S !== v[8:1] || Cout !== v[0]) begin
        errors++;
        $display("FAIL carry_out[%0d] %h+%h+%b: got Cout=%b S=%h required Cout=%b S=%h",
                 i, v[25:18], v[17:10], v[9], Cout, S, v[0], v[8:1]);
      end
    end
  endtask

  task automatic test_propagate();
    logic [25:0] v;
    for (int i = 0; i < 3; i++) begin
      v = PROP_VEC[i];
      @(negedge clk);
      A = v[25:18]; B = v[17:10]; Cin = v[9];
      @(posedge clk);
      #1;
      checks++;
      if (S !== v[8:1] || Cout !== v[0]) begin
        errors++;
        $display("FAIL propagate[%0d] %h+%h+%b: got Cout=%b S=%h required Cout=%b S=%h",
                 i, v[25:18], v[17:10], v[9], Cout, S, v[0], v[8:1]);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    A = 8'h5A; B = 8'h33; Cin = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({Cout, S} !== 9'h08E) begin
      errors++;
      $display("FAIL async_pre: got Cout=%b S=%h required Cout=0 S=8e", Cout, S);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({Cout, S} !== 9'h000) begin
      errors++;
      $display("FAIL async_clear: got Cout=%b S=%h required Cout=0 S=00", Cout, S);
    end
    @(negedge clk);
    rst = 1'b0;
    A = 8'h80; B = 8'h80; Cin = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({Cout, S} !== 9'h100) begin
      errors++;
      $display("FAIL async_release: got Cout=%b S=%h required Cout=1 S=00", Cout, S);
    end
  endtask

  task automatic test_random();
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [8:0] exp_sum;
    int         bad;
    bad = 0;
    for (int i = 0; i < 12000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      exp_sum = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      @(negedge clk);
      A = ra; B = rb; Cin = rc;
      @(posedge clk);
      #1;
      checks++;
      if ({Cout, S} !== exp_sum) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d] %h+%h+%b: got %h required %h", i, ra, rb, rc, {Cout, S}, exp_sum);
      end
      A = ~ra; B = 8'($urandom); Cin = ~rc;
      #2;
      checks++;
      if ({Cout, S} !== exp_sum) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_hold[%0d]: got %h required %h", i, {Cout, S}, exp_sum);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_carry_out();
    test_propagate();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
